// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port data memory between the pipeline
// MEM stage (priority) and the loader/debug port. A saturating starvation
// counter guarantees the loader a slot after STARVE_LIMIT blocked cycles.
module dmem_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, cnt_nxt, cnt_inc;
    logic             cpu_acc;
    logic             ldr_serve;

    assign cpu_acc   = cpu_read | cpu_write;
    // ACK cycle always belongs to the CPU; otherwise loader wins when CPU is idle or starved
    assign ldr_serve = ldr_req & (state != ACK) & (~cpu_acc | (starve_cnt >= LIMIT));
    assign cnt_inc   = (starve_cnt >= LIMIT) ? starve_cnt : starve_cnt + CNT_W'(1);
    assign cpu_rdata = mem_rdata;

    // Memory port mux: loader slot stalls any CPU access; a CPU write suppresses its read
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_write = cpu_write;
        mem_read  = cpu_read & ~cpu_write;
        cpu_stall = 1'b0;
        if (ldr_serve) begin
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
            mem_write = ldr_we;
            mem_read  = ~ldr_we;
            cpu_stall = cpu_acc;
        end
    end

    // Next-state and starvation counter update
    always_comb begin
        state_nxt = state;
        cnt_nxt   = starve_cnt;
        case (state)
            IDLE: begin
                if (ldr_serve) begin
                    state_nxt = ACK;
                    cnt_nxt   = '0;
                end else if (ldr_req) begin
                    state_nxt = WAIT;
                    cnt_nxt   = cnt_inc;
                end
            end
            WAIT: begin
                if (ldr_serve) begin
                    state_nxt = ACK;
                    cnt_nxt   = '0;
                end else if (!ldr_req) begin
                    // requester abandoned the access without an ack
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            ACK: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered loader response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            ldr_ack    <= 1'b0;
            ldr_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= cnt_nxt;
            ldr_ack    <= ldr_serve;
            if (ldr_serve && !ldr_we)
                ldr_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: instance a uses STARVE_LIMIT=4,
// instance b uses STARVE_LIMIT=0. Each has a small behavioural datam.
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // instance a (STARVE_LIMIT=4)
    logic        a_cpu_read, a_cpu_write, a_cpu_stall;
    logic [31:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
    logic        a_ldr_req, a_ldr_we, a_ldr_ack;
    logic [31:0] a_ldr_addr, a_ldr_wdata, a_ldr_rdata;
    logic        a_mem_read, a_mem_write;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [31:0] a_mem [16];

    // instance b (STARVE_LIMIT=0)
    logic        b_cpu_read, b_cpu_write, b_cpu_stall;
    logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
    logic        b_ldr_req, b_ldr_we, b_ldr_ack;
    logic [31:0] b_ldr_addr, b_ldr_wdata, b_ldr_rdata;
    logic        b_mem_read, b_mem_write;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [31:0] b_mem [16];

    dmem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_LIMIT(4)) u_a (
        .clk(clk), .reset(reset),
        .cpu_read(a_cpu_read), .cpu_write(a_cpu_write), .cpu_addr(a_cpu_addr),
        .cpu_wdata(a_cpu_wdata), .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
        .ldr_req(a_ldr_req), .ldr_we(a_ldr_we), .ldr_addr(a_ldr_addr),
        .ldr_wdata(a_ldr_wdata), .ldr_ack(a_ldr_ack), .ldr_rdata(a_ldr_rdata),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    dmem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_LIMIT(0)) u_b (
        .clk(clk), .reset(reset),
        .cpu_read(b_cpu_read), .cpu_write(b_cpu_write), .cpu_addr(b_cpu_addr),
        .cpu_wdata(b_cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
        .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr),
        .ldr_wdata(b_ldr_wdata), .ldr_ack(b_ldr_ack), .ldr_rdata(b_ldr_rdata),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // behavioural datam models: combinational read, clocked write
    assign a_mem_rdata = a_mem[a_mem_addr[3:0]];
    assign b_mem_rdata = b_mem[b_mem_addr[3:0]];
    always @(posedge clk) if (a_mem_write) a_mem[a_mem_addr[3:0]] <= a_mem_wdata;
    always @(posedge clk) if (b_mem_write) b_mem[b_mem_addr[3:0]] <= b_mem_wdata;

    // scoreboard
    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty: observed %0h required a queued entry", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.v) else begin
                n_err++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        a_cpu_read = 0; a_cpu_write = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
        a_ldr_req = 0; a_ldr_we = 0; a_ldr_addr = 0; a_ldr_wdata = 0;
        b_cpu_read = 0; b_cpu_write = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        b_ldr_req = 0; b_ldr_we = 0; b_ldr_addr = 0; b_ldr_wdata = 0;

        // reset state
        push("rst_ack", 0); push("rst_rdata", 0); push("rst_stall", 0);
        push("rst_mwr", 0); push("rst_mrd", 0);
        smp();
        pop_chk(32'(a_ldr_ack)); pop_chk(a_ldr_rdata); pop_chk(32'(a_cpu_stall));
        pop_chk(32'(a_mem_write)); pop_chk(32'(a_mem_read));
        cyc();
        reset = 1'b1;

        // 1. CPU only: store 77 to 5, then load it back
        a_cpu_write = 1; a_cpu_addr = 5; a_cpu_wdata = 77;
        push("t1_mwr", 1); push("t1_maddr", 5); push("t1_mwdata", 77); push("t1_stall_w", 0);
        smp();
        pop_chk(32'(a_mem_write)); pop_chk(a_mem_addr); pop_chk(a_mem_wdata); pop_chk(32'(a_cpu_stall));
        cyc();
        a_cpu_write = 0; a_cpu_read = 1;
        push("t1_mrd", 1); push("t1_rdata", 77); push("t1_stall_r", 0);
        smp();
        pop_chk(32'(a_mem_read)); pop_chk(a_cpu_rdata); pop_chk(32'(a_cpu_stall));
        cyc();
        // preload mem[2]=31 through the CPU port
        a_cpu_read = 0; a_cpu_write = 1; a_cpu_addr = 2; a_cpu_wdata = 31;
        cyc();
        a_cpu_write = 0;
        cyc();

        // 2. Loader read of addr 2 with CPU idle
        a_ldr_req = 1; a_ldr_we = 0; a_ldr_addr = 2;
        push("t2_mrd", 1); push("t2_maddr", 2); push("t2_ack0", 0); push("t2_stall", 0);
        smp();
        pop_chk(32'(a_mem_read)); pop_chk(a_mem_addr); pop_chk(32'(a_ldr_ack)); pop_chk(32'(a_cpu_stall));
        cyc();
        // ldr_req still high during ack: must be ignored
        push("t2_ack1", 1); push("t2_rdata", 31); push("t2_ign_rd", 0);
        smp();
        pop_chk(32'(a_ldr_ack)); pop_chk(a_ldr_rdata); pop_chk(32'(a_mem_read));
        cyc();
        a_ldr_req = 0;
        push("t2_ack_pulse", 0); push("t2_rdata_hold", 31);
        smp();
        pop_chk(32'(a_ldr_ack)); pop_chk(a_ldr_rdata);
        cyc();

        // 3. Starvation: CPU reads every cycle, loader served in cycle 4
        a_cpu_read = 1; a_cpu_addr = 5;
        a_ldr_req = 1; a_ldr_we = 0; a_ldr_addr = 2;
        for (int c = 0; c < 6; c++) begin
            push($sformatf("t3_stall_c%0d", c), (c == 4) ? 1 : 0);
            push($sformatf("t3_maddr_c%0d", c), (c == 4) ? 2 : 5);
            push($sformatf("t3_ack_c%0d", c), (c == 5) ? 1 : 0);
            smp();
            pop_chk(32'(a_cpu_stall)); pop_chk(a_mem_addr); pop_chk(32'(a_ldr_ack));
            cyc();
        end
        a_ldr_req = 0; a_cpu_read = 0;
        cyc();

        // 4. read and write together: write wins
        a_cpu_read = 1; a_cpu_write = 1; a_cpu_addr = 9; a_cpu_wdata = 3;
        push("t4_mwr", 1); push("t4_mrd", 0);
        smp();
        pop_chk(32'(a_mem_write)); pop_chk(32'(a_mem_read));
        cyc();
        a_cpu_write = 0;
        push("t4_rdata", 3);
        smp();
        pop_chk(a_cpu_rdata);
        cyc();
        a_cpu_read = 0;
        cyc();

        // 5. reset while WAIT with starve_cnt=2
        a_cpu_read = 1; a_cpu_addr = 5;
        a_ldr_req = 1; a_ldr_we = 0; a_ldr_addr = 9;
        cyc();
        cyc();
        push("t5_cnt_pre", 2);
        smp();
        pop_chk(32'(u_a.starve_cnt));
        @(posedge clk); #1;
        reset = 1'b0;
        push("t5_ack_rst", 0); push("t5_cnt_rst", 0); push("t5_stall_rst", 0);
        smp();
        pop_chk(32'(a_ldr_ack)); pop_chk(32'(u_a.starve_cnt)); pop_chk(32'(a_cpu_stall));
        cyc();
        reset = 1'b1; a_cpu_read = 0;
        push("t5_serve_rd", 1); push("t5_serve_addr", 9);
        smp();
        pop_chk(32'(a_mem_read)); pop_chk(a_mem_addr);
        cyc();
        push("t5_ack", 1); push("t5_rdata", 3);
        smp();
        pop_chk(32'(a_ldr_ack)); pop_chk(a_ldr_rdata);
        cyc();
        a_ldr_req = 0;
        cyc();

        // 6. STARVE_LIMIT=0: loader write beats a CPU write to the same address
        b_cpu_write = 1; b_cpu_addr = 7; b_cpu_wdata = 11;
        b_ldr_req = 1; b_ldr_we = 1; b_ldr_addr = 7; b_ldr_wdata = 22;
        push("t6_stall", 1); push("t6_mwr", 1); push("t6_mwdata_ldr", 22); push("t6_maddr", 7);
        smp();
        pop_chk(32'(b_cpu_stall)); pop_chk(32'(b_mem_write)); pop_chk(b_mem_wdata); pop_chk(b_mem_addr);
        cyc();
        push("t6_ack", 1); push("t6_stall_ack", 0); push("t6_mwdata_cpu", 11); push("t6_landed", 22);
        smp();
        pop_chk(32'(b_ldr_ack)); pop_chk(32'(b_cpu_stall)); pop_chk(b_mem_wdata); pop_chk(b_mem[7]);
        cyc();
        b_ldr_req = 0; b_cpu_write = 0; b_cpu_read = 1;
        push("t6_final", 11); push("t6_stall_rd", 0);
        smp();
        pop_chk(b_cpu_rdata); pop_chk(32'(b_cpu_stall));
        cyc();
        b_cpu_read = 0;

        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_leftover: observed %0d entries required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
